corrimiento_secuencial: RTL and testbench
=========================================

// Module: corrimiento_secuencial
// PURPOSE
//  Multi-cycle ARM shifter for the ALU operand-2 path. Supports LSL, LSR, ASR, ROR and RRX with ARM carry-out semantics.
//  Shifts at most STEP bits per cycle, trading latency for area.
//  Uses valid/ready on both sides and sits between the decode operand latch and the ALU.
// PARAMETERS
//  N     32  data width; power of 2, >=8
//  STEP  8   max bits shifted per cycle; power of 2, 1..N
//  AW    8   shift-amount width (ARM register shifts use the low byte)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active low
//  in_valid   in   1     operation request
//  in_ready   out  1     block can accept an operation
//  a          in   N     operand
//  amt        in   AW    shift amount
//  mode       in   3     0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 reserved
//  c_in       in   1     carry flag in
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  z          out  N     result
//  c_out      out  1     shifter carry out
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE, z=0, c_out=0, out_valid=0.
//   - in_ready=0 while rst_n=0; it is 1 from the first edge after release.
//  FSM:
//   - IDLE: in_ready=1. On in_valid&in_ready, latch a, mode, c_in and rem, then go to RUN or DONE.
//   - RUN: each cycle k=min(rem,STEP); shift the working register by k; c = last bit shifted out; rem-=k.
//     Go to DONE when rem hits 0.
//   - DONE: out_valid=1; z and c_out are held stable. On out_valid&out_ready go to IDLE.
//  rem at accept:
//   - LSL/LSR/ASR: min(amt, N+1). Iterating naturally gives z=0 or sign fill, and c = a[0]/a[N-1] at amt==N, else 0/sign.
//   - ROR: amt mod N.
//  Zero-work ops go straight to DONE (1 cycle):
//   - amt==0 (any mode except RRX): z=a, c_out=c_in.
//   - ROR with amt!=0 and amt%N==0: z=a, c_out=a[N-1].
//   - RRX: z={c_in,a[N-1:1]}, c_out=a[0]; amt is ignored.
//   - reserved mode: z=a, c_out=c_in.
//  Result carry:
//   - ROR nonzero: c_out=z[N-1].
//   - LSL/LSR/ASR: c_out = last bit shifted out.
//  Latency, accept edge to out_valid:
//   - ceil(rem/STEP)+1 cycles.
//   - 1 cycle for zero-work ops.
//  Handshake:
//   - Inputs are sampled only on the accept edge; changes afterwards are ignored.
//   - in_valid while not ready is held by the producer, never dropped.
//  Reset mid-operation: the op is discarded, no result is emitted, and the FSM returns to IDLE.
// CONFIGURATION
//  CORRIMIENTO_FASTPATH_EN
//   - Defined: in_ready = IDLE | (DONE & out_ready). A new op may be accepted on the same edge as the result handoff.
//     Zero-work ops then sustain 1 op/cycle.
//   - Undefined: in_ready only in IDLE, giving at least 1 bubble cycle between ops.
//     Results are identical either way; only throughput differs.
// TESTING (N=8, STEP=4, out_ready=1 unless stated)
//  1. ROR a=8'hB5 amt=3 -> z=8'hB6, c_out=1, out_valid 2 cycles after accept.
//  2. LSL a=8'h81: amt=8 -> z=8'h00, c_out=1, latency 3. Then amt=9 -> z=8'h00, c_out=0.
//  3. ASR a=8'h90 amt=200 -> z=8'hFF, c_out=1, latency 4. RRX a=8'h03 c_in=1 -> z=8'h81, c_out=1, latency 1.
//  4. ROR a=8'h5A amt=16 -> z=8'h5A, c_out=0. LSR a=8'h5A amt=0 c_in=1 -> z=8'h5A, c_out=1. Both latency 1.
//  5. Backpressure: out_ready=0 for 5 cycles in DONE -> z/c_out stable, in_ready=0.
//     Then rst_n pulsed low mid-RUN -> out_valid=0 immediately, in_ready=1 after release.
//  6. Stream 4 RRX ops with in_valid=1 -> with CORRIMIENTO_FASTPATH_EN, out_valid high 4 consecutive cycles;
//     without it, results every 2 cycles.

Source files
------------

// File: rtl/corrimiento_secuencial.sv
// ---------------------------------------------------------------------------
// corrimiento_secuencial
//
// Multi-cycle ARM barrel-shifter replacement for the ALU operand-2 path.
// Implements LSL, LSR, ASR, ROR and RRX with ARM carry-out semantics while
// moving at most STEP bit positions per clock, so a wide shift is spread over
// several cycles instead of needing a full log2(N)-level barrel shifter.
//
// Parameters
//   N     data width (power of 2, >= 8)
//   STEP  maximum bit positions shifted per cycle (power of 2, 1..N)
//   AW    shift-amount width (register-specified shifts use the low byte)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   operation request from the decode operand latch
//   in_ready   shifter can accept an operation this cycle
//   a          operand
//   amt        shift amount
//   mode       0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 reserved (pass-through)
//   c_in       incoming carry flag
//   out_valid  result is available on z / c_out
//   out_ready  ALU accepts the result
//   z          shifted result (held stable while out_valid is high)
//   c_out      shifter carry out
//   busy       high whenever the FSM is not IDLE
//
// Configuration macro
//   CORRIMIENTO_FASTPATH_EN  when defined, a new operation may be accepted on
//                            the same edge that hands the previous result to
//                            the ALU; zero-work operations then stream at one
//                            per cycle. Results are identical either way.
// ---------------------------------------------------------------------------
module corrimiento_secuencial #(
    parameter int N    = 32,
    parameter int STEP = 8,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [AW-1:0] amt,
    input  logic [2:0]    mode,
    input  logic          c_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  z,
    output logic          c_out,
    output logic          busy
);

    // rem never exceeds N+1 (linear shifts are clamped there)
    localparam int RW = $clog2(N + 2);
    // per-cycle step k ranges over 0..STEP
    localparam int KW = $clog2(STEP + 1);

    localparam logic [31:0]   N_U    = 32'(N);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_RRX = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  work;
    logic [N-1:0]  work_nx;
    logic          carry;
    logic          carry_nx;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_nx;
    logic [2:0]    op;
    logic [2:0]    op_nx;
    // Low during reset and until the first edge after release; gates in_ready
    // so nothing is accepted while the block is coming out of reset.
    logic          live;

    logic          accept;
    logic [KW-1:0] k;
    logic [N:0]    stepped;
    logic [31:0]   amt_w;
    logic [RW-1:0] rem_lin;
    logic [RW-1:0] rem_rot;

    // -----------------------------------------------------------------------
    // One shift step of k positions (1 <= k <= STEP). Returns {carry, value}
    // where carry is the last bit that left the register. The operand is
    // widened by one bit so the outgoing bit lands in a fixed position and no
    // variable-index arithmetic is needed.
    // -----------------------------------------------------------------------
    function automatic logic [N:0] shift_step(
        input logic [2:0]    m,
        input logic [N-1:0]  w,
        input logic [KW-1:0] kk
    );
        logic [N:0]          ext;
        logic signed [N:0]   sext;
        logic [2*N-1:0]      dbl;
        logic [N:0]          res;
        ext  = '0;
        sext = '0;
        dbl  = '0;
        res  = {1'b0, w};
        case (m)
            MODE_LSL: begin
                // top bit of the widened word is the last bit pushed out
                ext = {1'b0, w} << kk;
                res = ext;
            end
            MODE_LSR: begin
                ext = {w, 1'b0} >> kk;
                res = {ext[0], ext[N:1]};
            end
            MODE_ASR: begin
                sext = $signed({w, 1'b0}) >>> kk;
                res  = {sext[0], sext[N:1]};
            end
            MODE_ROR: begin
                // the bit rotated out of position 0 lands in the MSB
                dbl = {w, w} >> kk;
                res = {dbl[N-1], dbl[N-1:0]};
            end
            default: res = {1'b0, w};
        endcase
        return res;
    endfunction

    // Amount decode for the accept edge
    always_comb begin
        amt_w   = 32'(amt);
        rem_lin = (amt_w > (N_U + 32'd1)) ? RW'(N_U + 32'd1) : RW'(amt_w);
        rem_rot = RW'(amt_w % N_U);
    end

    // Per-cycle step size: min(rem, STEP)
    always_comb begin
        k       = (rem > STEP_R) ? KW'(STEP) : KW'(rem);
        stepped = shift_step(op, work, k);
    end

    // -----------------------------------------------------------------------
    // FSM: next state, datapath next values and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        work_nx   = work;
        carry_nx  = carry;
        rem_nx    = rem;
        op_nx     = op;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
`ifdef CORRIMIENTO_FASTPATH_EN
        in_ready  = live & ((state == IDLE) | ((state == DONE) & out_ready));
`else
        in_ready  = live & (state == IDLE);
`endif
        accept    = in_valid & in_ready;

        case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            RUN: begin
                work_nx  = stepped[N-1:0];
                carry_nx = stepped[N];
                rem_nx   = rem - RW'(k);
                if (rem == RW'(k)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A new operation overrides the DONE->IDLE move on the fast path.
        // Zero-work operations resolve here and go straight to DONE.
        if (accept) begin
            op_nx    = mode;
            work_nx  = a;
            carry_nx = c_in;
            rem_nx   = '0;
            state_nx = DONE;
            case (mode)
                MODE_RRX: begin
                    work_nx  = {c_in, a[N-1:1]};
                    carry_nx = a[0];
                end
                MODE_ROR: begin
                    if (amt != '0) begin
                        if (rem_rot == '0) begin
                            // full rotations: value unchanged, carry = MSB
                            carry_nx = a[N-1];
                        end else begin
                            rem_nx   = rem_rot;
                            state_nx = RUN;
                        end
                    end
                end
                MODE_LSL, MODE_LSR, MODE_ASR: begin
                    // clamping at N+1 lets the step loop produce the ARM
                    // results for amt==N and amt>N without special cases
                    if (amt != '0) begin
                        rem_nx   = rem_lin;
                        state_nx = RUN;
                    end
                end
                default: begin
                    // reserved encodings pass the operand and carry through
                    state_nx = DONE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
            work  <= '0;
            carry <= 1'b0;
            rem   <= '0;
            op    <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            work  <= work_nx;
            carry <= carry_nx;
            rem   <= rem_nx;
            op    <= op_nx;
        end
    end

    assign z     = work;
    assign c_out = carry;

endmodule

// File: tb/tb_corrimiento_secuencial.sv
`timescale 1ns/1ps
module tb_corrimiento_secuencial;

    localparam int N    = 8;
    localparam int STEP = 4;
    localparam int AW   = 8;

`ifdef CORRIMIENTO_FASTPATH_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [AW-1:0] amt = '0;
    logic [2:0]    mode = '0;
    logic          c_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  z;
    logic          c_out;
    logic          busy;

    corrimiento_secuencial #(.N(N), .STEP(STEP), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .amt      (amt),
        .mode     (mode),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z),
        .c_out    (c_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] amt;
        logic       cin;
        logic [7:0] z;
        logic       c;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] z;
        logic       c;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   first_cyc = 0;
    bit   have_first = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model written straight from the ARM shift definitions
    function automatic vec_t model(input logic [2:0] m, input logic [7:0] av,
                                   input logic [7:0] s8, input logic ci);
        vec_t       v;
        int         s;
        int         r;
        logic [7:0] t;
        s      = int'(s8);
        v.mode = m;  v.a = av;  v.amt = s8;  v.cin = ci;
        v.z    = av; v.c = ci;  v.lat = 1;
        case (m)
            3'd0, 3'd1, 3'd2: begin
                if (s != 0) begin
                    v.lat = (((s > 9) ? 9 : s) + 3) / 4 + 1;
                    if (s < 8) begin
                        if (m == 3'd0) begin
                            v.z = av << s;  v.c = av[8-s];
                        end else if (m == 3'd1) begin
                            v.z = av >> s;  v.c = av[s-1];
                        end else begin
                            t = $signed(av) >>> s;
                            v.z = t;  v.c = av[s-1];
                        end
                    end else if (s == 8) begin
                        if (m == 3'd0)      begin v.z = 8'h00;       v.c = av[0]; end
                        else if (m == 3'd1) begin v.z = 8'h00;       v.c = av[7]; end
                        else                begin v.z = {8{av[7]}};  v.c = av[7]; end
                    end else begin
                        if (m == 3'd2) begin v.z = {8{av[7]}}; v.c = av[7]; end
                        else           begin v.z = 8'h00;      v.c = 1'b0;  end
                    end
                end
            end
            3'd3: begin
                if (s != 0) begin
                    r = s % 8;
                    if (r == 0) begin
                        v.c = av[7];
                    end else begin
                        t = (av >> r) | (av << (8 - r));
                        v.z = t;  v.c = t[7];  v.lat = (r + 3) / 4 + 1;
                    end
                end
            end
            3'd4: begin
                v.z = {ci, av[7:1]};  v.c = av[0];
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic vec_t mk(input logic [2:0] m, input logic [7:0] av, input logic [7:0] s8,
                                input logic ci, input logic [7:0] ez, input logic ec, input int el);
        vec_t v;
        v.mode = m; v.a = av; v.amt = s8; v.cin = ci; v.z = ez; v.c = ec; v.lat = el;
        return v;
    endfunction

    // Result monitor: compares every handed-off result against the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid) begin
            if (!have_first) begin
                first_cyc  = cyc;
                have_first = 1'b1;
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("z", 32'(z), 32'(e.z));
                    check("c_out", 32'(c_out), 32'(e.c));
                    check("latency", 32'(first_cyc - e.acc + 1), 32'(e.lat));
                    hs_cyc.push_back(cyc);
                end
                have_first = 1'b0;
            end
        end
    end

    task automatic do_op(input vec_t v, input bit keep);
        int g;
        g = 0;
        @(negedge clk);
        mode = v.mode; a = v.a; amt = v.amt; c_in = v.cin; in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("in_ready wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{v.z, v.c, v.lat, cyc + 1});
        @(posedge clk);
        #1;
        // scramble the inputs after the accept edge; they must be ignored
        a = 8'($urandom); amt = 8'($urandom); c_in = 1'($urandom); mode = 3'($urandom);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   g;

        tbl.push_back(mk(3'd3, 8'hB5, 8'd3,   1'b0, 8'hB6, 1'b1, 2));
        tbl.push_back(mk(3'd0, 8'h81, 8'd8,   1'b0, 8'h00, 1'b1, 3));
        tbl.push_back(mk(3'd0, 8'h81, 8'd9,   1'b0, 8'h00, 1'b0, 4));
        tbl.push_back(mk(3'd2, 8'h90, 8'd200, 1'b0, 8'hFF, 1'b1, 4));
        tbl.push_back(mk(3'd4, 8'h03, 8'd0,   1'b1, 8'h81, 1'b1, 1));
        tbl.push_back(mk(3'd3, 8'h5A, 8'd16,  1'b0, 8'h5A, 1'b0, 1));
        tbl.push_back(mk(3'd1, 8'h5A, 8'd0,   1'b1, 8'h5A, 1'b1, 1));
        tbl.push_back(mk(3'd1, 8'h80, 8'd7,   1'b0, 8'h01, 1'b0, 3));
        tbl.push_back(mk(3'd2, 8'h80, 8'd1,   1'b0, 8'hC0, 1'b0, 2));
        tbl.push_back(mk(3'd0, 8'h0F, 8'd5,   1'b0, 8'hE0, 1'b1, 3));
        tbl.push_back(mk(3'd6, 8'h3C, 8'd5,   1'b1, 8'h3C, 1'b1, 1));
        tbl.push_back(mk(3'd3, 8'h01, 8'd9,   1'b0, 8'h80, 1'b1, 2));
        tbl.push_back(mk(3'd1, 8'hFF, 8'd8,   1'b0, 8'h00, 1'b1, 3));
        tbl.push_back(mk(3'd2, 8'h7F, 8'd9,   1'b0, 8'h00, 1'b0, 4));
        tbl.push_back(mk(3'd4, 8'h02, 8'd50,  1'b0, 8'h01, 1'b0, 1));
        tbl.push_back(mk(3'd0, 8'h80, 8'd1,   1'b0, 8'h00, 1'b1, 2));

        // reset state
        #1 rst_n = 1'b0;
        #11;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset z", 32'(z), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        #1 check("in_ready before first edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready after release", 32'(in_ready), 32'd1);

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i], 1'b0);
            drain();
        end

        // model-checked random operations
        for (int i = 0; i < 24; i++) begin
            v = model(3'($urandom_range(0, 7)), 8'($urandom),
                      (i % 2 == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom), 1'($urandom));
            do_op(v, 1'b0);
            drain();
        end

        // backpressure: result held while the ALU stalls
        out_ready = 1'b0;
        do_op(mk(3'd0, 8'h0F, 8'd5, 1'b0, 8'hE0, 1'b1, 3), 1'b0);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall z", 32'(z), 32'hE0);
            check("stall c_out", 32'(c_out), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // reset in the middle of a long operation
        do_op(mk(3'd2, 8'h90, 8'd200, 1'b0, 8'hFF, 1'b1, 4), 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midrst busy before", 32'(busy), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst z", 32'(z), 32'd0);
        sb.delete();
        have_first = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst in_ready after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no result", 32'(out_valid), 32'd0);
        end
        do_op(mk(3'd3, 8'hB5, 8'd3, 1'b0, 8'hB6, 1'b1, 2), 1'b0);
        drain();

        // stream of RRX operations with in_valid held high
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            v = model(3'd4, 8'($urandom), 8'($urandom), 1'($urandom));
            do_op(v, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        check("stream results", 32'(hs_cyc.size()), 32'd4);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("stream gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(EXP_GAP));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
